// File: rtl/div4_gear_tx.sv
`default_nettype none
// ============================================================================
// Module      : div4_gear_tx
// Description : Soft 4:1 transmit gearbox in the fast hclkin domain. Samples
//               the divided clock as data, recovers its phase within each
//               4-cycle word period with lock/error tracking, and serializes
//               a parallel word LSB first onto per-lane 1-bit outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module div4_gear_tx #(
   parameter int LANES    = 1,
   parameter int LOCK_CNT = 8
) (
   input  logic                 hclkin,
   input  logic                 resetn,
   input  logic                 div_clk_in,
   input  logic [4*LANES-1:0]   data_in,
   output logic [LANES-1:0]     ser_out,
   output logic                 word_strobe,
   output logic [1:0]           phase,
   output logic                 locked,
   output logic                 align_err
);

   localparam int                c_cnt_w     = $clog2(LOCK_CNT) + 1;
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_cnt_max   = {c_cnt_w{1'b1}};
   localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_CNT - 1);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t               state_q;
   logic                 sync1_q;
   logic                 sync2_q;
   logic                 dly_q;
   logic                 rise_d;
   logic [1:0]           phase_q;
   logic [c_cnt_w-1:0]   good_cnt_q;
   logic [c_cnt_w-1:0]   good_cnt_inc_d;
   logic                 locked_q;
   logic                 align_err_q;
   logic                 word_strobe_q;
   logic [LANES-1:0]     ser_q;
   logic [LANES-1:0]     ser_load_d;
   logic [LANES-1:0]     ser_shift_d;
   // Bit 0 of each lane goes straight to ser_q at load, so only bits 1..3
   // need to be held for the rest of the word.
   logic [3*LANES-1:0]   shift_q;
   logic [3*LANES-1:0]   shift_load_d;
   logic [3*LANES-1:0]   shift_next_d;

   // Bring the divided clock into hclkin domain and keep one older sample.
   always_ff @(posedge hclkin or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dly_q   <= 1'b0;
      end else begin
         sync1_q <= div_clk_in;
         sync2_q <= sync1_q;
         dly_q   <= sync2_q;
      end
   end

   assign rise_d = sync2_q & ~dly_q;

   assign good_cnt_inc_d = (good_cnt_q == c_cnt_max) ? good_cnt_q
                                                     : good_cnt_q + c_cnt_one;

   // Per-lane split of the incoming word and of the shift register.
   always_comb begin
      ser_load_d   = '0;
      ser_shift_d  = '0;
      shift_load_d = '0;
      shift_next_d = '0;
      for (int k = 0; k < LANES; k++) begin
         ser_load_d[k]          = data_in[4*k];
         shift_load_d[3*k +: 3] = data_in[4*k+1 +: 3];
         ser_shift_d[k]         = shift_q[3*k];
         shift_next_d[3*k +: 3] = {1'b0, shift_q[3*k+1 +: 2]};
      end
   end

   // Phase recovery / lock FSM with the serializer and all registered outputs.
   // A detected edge is treated as the phase-3 slot of its period, so the
   // cycle after any accepted or realigning edge is phase 0 and the next
   // clean edge lands exactly on phase 3.
   always_ff @(posedge hclkin or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_HUNT;
         phase_q       <= 2'd0;
         good_cnt_q    <= '0;
         locked_q      <= 1'b0;
         align_err_q   <= 1'b0;
         word_strobe_q <= 1'b0;
         ser_q         <= '0;
         shift_q       <= '0;
      end else begin
         align_err_q   <= 1'b0;
         word_strobe_q <= 1'b0;
         case (state_q)
            ST_HUNT: begin
               phase_q  <= 2'd0;
               ser_q    <= '0;
               shift_q  <= '0;
               locked_q <= 1'b0;
               if (rise_d) begin
                  state_q    <= ST_VERIFY;
                  good_cnt_q <= '0;
               end
            end
            ST_VERIFY: begin
               ser_q   <= '0;
               shift_q <= '0;
               if (rise_d && (phase_q == 2'd3)) begin
                  phase_q    <= 2'd0;
                  good_cnt_q <= good_cnt_inc_d;
                  if (good_cnt_q == c_lock_last) begin
                     state_q  <= ST_LOCKED;
                     locked_q <= 1'b1;
                  end
               end else if (rise_d) begin
                  phase_q    <= 2'd0;
                  good_cnt_q <= '0;
               end else if (phase_q == 2'd3) begin
                  state_q    <= ST_HUNT;
                  phase_q    <= 2'd0;
                  good_cnt_q <= '0;
               end else begin
                  phase_q <= phase_q + 2'd1;
               end
            end
            ST_LOCKED: begin
               if (rise_d && (phase_q == 2'd3)) begin
                  phase_q       <= 2'd0;
                  good_cnt_q    <= good_cnt_inc_d;
                  ser_q         <= ser_load_d;
                  shift_q       <= shift_load_d;
                  word_strobe_q <= 1'b1;
               end else if (rise_d) begin
                  state_q     <= ST_VERIFY;
                  phase_q     <= 2'd0;
                  good_cnt_q  <= '0;
                  locked_q    <= 1'b0;
                  align_err_q <= 1'b1;
                  ser_q       <= '0;
                  shift_q     <= '0;
               end else if (phase_q == 2'd3) begin
                  state_q     <= ST_HUNT;
                  phase_q     <= 2'd0;
                  good_cnt_q  <= '0;
                  locked_q    <= 1'b0;
                  align_err_q <= 1'b1;
                  ser_q       <= '0;
                  shift_q     <= '0;
               end else begin
                  phase_q <= phase_q + 2'd1;
                  ser_q   <= ser_shift_d;
                  shift_q <= shift_next_d;
               end
            end
            default: begin
               state_q    <= ST_HUNT;
               phase_q    <= 2'd0;
               good_cnt_q <= '0;
               locked_q   <= 1'b0;
               ser_q      <= '0;
               shift_q    <= '0;
            end
         endcase
      end
   end

   assign ser_out     = ser_q;
   assign word_strobe = word_strobe_q;
   assign phase       = phase_q;
   assign locked      = locked_q;
   assign align_err   = align_err_q;

endmodule
`default_nettype wire

// File: tb/tb_div4_gear_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_div4_gear_tx
// Description : Self-checking bench for div4_gear_tx (LANES=2). A timestamp
//               based reference model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div4_gear_tx;

   localparam int LANES    = 2;
   localparam int LOCK_CNT = 8;

   logic                 hclkin     = 1'b0;
   logic                 resetn     = 1'b0;
   logic                 div_clk_in = 1'b0;
   logic [4*LANES-1:0]   data_in    = '0;
   logic [LANES-1:0]     ser_out;
   logic                 word_strobe;
   logic [1:0]           phase;
   logic                 locked;
   logic                 align_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 hclkin = ~hclkin;

   div4_gear_tx #(
      .LANES    (LANES),
      .LOCK_CNT (LOCK_CNT)
   ) u_dut (
      .hclkin      (hclkin),
      .resetn      (resetn),
      .div_clk_in  (div_clk_in),
      .data_in     (data_in),
      .ser_out     (ser_out),
      .word_strobe (word_strobe),
      .phase       (phase),
      .locked      (locked),
      .align_err   (align_err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- divided-clock generator ----------------
   int  gen_pos     = 0;
   int  gen_len     = 4;
   bit  hold_low    = 1'b0;
   bit  rand_len    = 1'b0;
   bit  rand_data   = 1'b0;
   bit  stretch_one = 1'b0;

   task automatic drive_inputs();
      int r;
      if (hold_low) begin
         div_clk_in = 1'b0;
      end else begin
         if (gen_pos == 0) begin
            if (rand_data) data_in = 8'($urandom);
            if (stretch_one) begin
               gen_len     = 5;
               stretch_one = 1'b0;
            end else if (rand_len) begin
               r = $urandom_range(0, 9);
               gen_len = (r == 0) ? 3 : (r == 1) ? 5 : (r == 2) ? 6 : 4;
            end else begin
               gen_len = 4;
            end
         end
         div_clk_in = (gen_pos < 2);
         gen_pos    = (gen_pos + 1) % gen_len;
      end
   endtask

   // ---------------- reference model ----------------
   // Mode 0 hunt, 1 verify, 2 locked. Alignment is kept as the cycle index of
   // the last edge that set it; the next edge is due exactly 4 cycles later.
   int          cyc      = 0;
   int          m_mode   = 0;
   int          m_anchor = 0;
   int          m_good   = 0;
   bit          m_have   = 1'b0;
   logic [7:0]  m_word   = '0;
   int          m_wstart = 0;
   bit          m_err    = 1'b0;
   int          m_rises  = 0;
   bit          a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
   int          err_obs  = 0;

   task automatic model_reset();
      m_mode = 0; m_good = 0; m_have = 1'b0; m_err = 1'b0; m_rises = 0;
      a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
   endtask

   task automatic model_step();
      bit rise;
      int d;
      // The edge is seen two samples after div_clk_in first reads high.
      rise = a2 & ~a3;
      a3 = a2; a2 = a1; a1 = div_clk_in;
      m_err = 1'b0;
      if (rise) m_rises++;
      if (m_mode == 0) begin
         if (rise) begin m_mode = 1; m_anchor = cyc; m_good = 0; end
      end else begin
         d = cyc - m_anchor;
         if (rise && d == 4) begin
            m_anchor = cyc;
            m_good++;
            if (m_mode == 2) begin
               m_word = data_in; m_wstart = cyc; m_have = 1'b1;
            end else if (m_good >= LOCK_CNT) begin
               m_mode = 2; m_have = 1'b0;
            end
         end else if (rise) begin
            if (m_mode == 2) m_err = 1'b1;
            m_mode = 1; m_anchor = cyc; m_good = 0; m_have = 1'b0;
         end else if (d == 4) begin
            if (m_mode == 2) m_err = 1'b1;
            m_mode = 0; m_good = 0; m_have = 1'b0;
         end
      end
   endtask

   function automatic logic [6:0] expected();
      logic [1:0] ser;
      logic [1:0] ph;
      logic       strb;
      int         k;
      ser  = 2'b00;
      strb = 1'b0;
      ph   = (m_mode == 0) ? 2'd0 : 2'((cyc - m_anchor) % 4);
      if (m_mode == 2 && m_have) begin
         k      = cyc - m_wstart;
         ser[0] = m_word[k];
         ser[1] = m_word[4 + k];
         strb   = (k == 0);
      end
      return {ser, strb, ph, (m_mode == 2), m_err};
   endfunction

   task automatic cycle();
      @(negedge hclkin);
      drive_inputs();
      @(posedge hclkin);
      cyc++;
      if (resetn) model_step(); else model_reset();
      #1;
      if (align_err === 1'b1) err_obs++;
      check_val($sformatf("cyc%0d", cyc),
                {25'd0, ser_out, word_strobe, phase, locked, align_err},
                {25'd0, expected()});
   endtask

   task automatic wait_lock(input string tag);
      for (int i = 0; i < 120 && locked !== 1'b1; i++) cycle();
      check_val(tag, {31'd0, locked}, 32'd1);
   endtask

   task automatic capture_word(input string tag, input logic [7:0] exp);
      logic [3:0] l0, l1;
      int         i;
      cycle();
      i = 0;
      while (word_strobe !== 1'b1 && i < 40) begin cycle(); i++; end
      check_val({tag, "_strb"}, {31'd0, word_strobe}, 32'd1);
      l0[0] = ser_out[0]; l1[0] = ser_out[1];
      for (int b = 1; b < 4; b++) begin
         cycle();
         l0[b] = ser_out[0]; l1[b] = ser_out[1];
      end
      check_val({tag, "_l0"}, {28'd0, l0}, {28'd0, exp[3:0]});
      check_val({tag, "_l1"}, {28'd0, l1}, {28'd0, exp[7:4]});
   endtask

   initial begin
      int e0;
      data_in = 8'hA5;
      resetn  = 1'b0;
      repeat (3) cycle();
      check_val("rst_state", {25'd0, ser_out, word_strobe, phase, locked, align_err}, 32'd0);

      // Clean divided clock from reset: 1 edge + 8 good edges to lock.
      gen_pos = 2;
      resetn  = 1'b1;
      wait_lock("lock1");
      check_val("lock1_edges", m_rises, 32'd9);
      e0 = err_obs;
      repeat (12) cycle();
      check_val("no_err", err_obs - e0, 32'd0);

      // Word contents, LSB first on both lanes.
      capture_word("w_a5", 8'hA5);
      data_in = 8'h4B;
      capture_word("w_4b", 8'h4B);
      data_in = 8'hB4;
      capture_word("w_b4", 8'hB4);

      // One period stretched to 5 cycles.
      e0 = err_obs;
      stretch_one = 1'b1;
      repeat (10) cycle();
      check_val("stretch_err", err_obs - e0, 32'd1);
      check_val("stretch_unlk", {31'd0, locked}, 32'd0);
      wait_lock("relock1");

      // Divided clock stops.
      e0 = err_obs;
      hold_low = 1'b1;
      repeat (12) cycle();
      check_val("miss_err", err_obs - e0, 32'd1);
      check_val("miss_hunt", {28'd0, phase, locked, word_strobe}, 32'd0);
      hold_low = 1'b0;
      gen_pos  = 0;
      wait_lock("relock2");

      // Asynchronous reset in the middle of a word.
      for (int i = 0; i < 20 && !(locked === 1'b1 && phase == 2'd2); i++) cycle();
      check_val("mid_word", {29'd0, locked, phase}, 32'd6);
      #2 resetn = 1'b0;
      #1 check_val("rst_async", {25'd0, ser_out, word_strobe, phase, locked, align_err}, 32'd0);
      repeat (2) cycle();
      gen_pos = 2;
      resetn  = 1'b1;
      wait_lock("lock2");
      check_val("lock2_edges", m_rises, 32'd9);

      // Random data and occasional irregular periods.
      rand_data = 1'b1;
      rand_len  = 1'b1;
      repeat (1500) cycle();
      rand_len = 1'b0;
      repeat (400) cycle();
      check_val("final_lock", {31'd0, locked}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/div4_gear_tx.md
Name: div4_gear_tx

Overview:
Soft 4:1 transmit gearbox in the fast hclkin domain, the consuming end of the divide-by-4 clock path. It samples the divided clock as data and recovers its phase within each 4-cycle word period, with lock/error tracking. It then serializes a parallel word held in the divided domain onto per-lane 1-bit outputs, LSB first, one bit per hclkin cycle. It sits between divided-clock pixel/control logic and fast-rate output pins.

Parameters:
LANES, 1, number of serial lanes; data_in width is 4*LANES.
LOCK_CNT, 8, consecutive correctly spaced divided-clock rising edges required before locked asserts; must be >= 1.

Ports:
hclkin  input  1  fast clock; all logic on rising edge.
resetn  input  1  asynchronous active-low reset.
div_clk_in  input  1  divided clock (hclkin/4), sampled as data.
data_in  input  4*LANES  parallel word; lane k uses bits [4k+3:4k]; held stable for a full divided period.
ser_out  output  LANES  serial data, one bit per hclkin cycle, LSB first.
word_strobe  output  1  one-cycle pulse on the cycle ser_out carries bit 0 of a new word.
phase  output  2  current bit index, 0..3.
locked  output  1  phase alignment valid.
align_err  output  1  one-cycle pulse on loss of alignment while locked.

Behaviour:
- Reset (resetn low, asynchronous): ser_out=0, word_strobe=0, phase=0, locked=0, align_err=0. Shift register and good-edge counter clear. State = HUNT. Reset clears all of these immediately, including mid-word.
- Input path: div_clk_in passes through a 2-flop synchronizer, then a delay flop.
- Edge detection: rise = sync & ~delayed.
- The fixed detection latency is irrelevant because phase is defined relative to the detected edge.
- An edge is "expected" when phase==3. Accepting an edge means phase wraps to 0 on the next cycle.
- State HUNT:
  - phase holds 0; ser_out=0.
  - On rise: phase<=1 next cycle (edge cycle counts as phase 0), good_cnt<=0, go to VERIFY.
- State VERIFY:
  - phase increments mod 4 each cycle.
  - rise at phase==3: good_cnt++. If good_cnt reaches LOCK_CNT-1, go to LOCKED and set locked=1 on the next cycle.
  - rise at phase!=3: realign (phase<=0 next cycle, sequence restarts), good_cnt<=0, stay in VERIFY.
  - no rise at phase==3: go to HUNT, good_cnt<=0.
- State LOCKED:
  - Good edge at phase==3: the cycle where phase==3 and rise coincide loads data_in into the shift register.
    - Next cycle: phase=0, ser_out=bit0 of each lane, word_strobe=1.
    - Following cycles: bit1, bit2, bit3.
    - data_in is sampled only on that load edge.
  - rise at phase!=3:
    - align_err=1 for one cycle, locked=0, good_cnt<=0.
    - Realign as in VERIFY and go to VERIFY.
    - ser_out=0 from the next cycle.
  - no rise at phase==3:
    - align_err=1 for one cycle, locked=0, go to HUNT, ser_out=0.
- Outside LOCKED, ser_out=0 and word_strobe=0. phase is valid in VERIFY/LOCKED and 0 in HUNT.
- All outputs are registered.
- good_cnt width is clog2(LOCK_CNT)+1 and it saturates; no wrap.
- Simultaneous events: at most one rise per cycle. A load and a mismatch cannot coincide, because a load requires phase==3.

Test Plan:
1. Reset release, then div_clk_in = clean hclkin/4 (2 high/2 low) -> locked=1 after the first edge plus 8 good edges. Afterwards word_strobe pulses every 4 cycles, phase cycles 0,1,2,3, align_err stays 0.
2. Locked, data_in=4'b1011 held -> ser_out = 1,1,0,1 over phases 0..3. Change to 4'b0100 -> next word is 0,0,1,0.
3. Locked, then stretch one divided period to 5 hclkin cycles -> one align_err pulse, locked=0, ser_out=0. Relock after 8 further good edges.
4. Locked, then hold div_clk_in low -> align_err pulse at the missing edge, state HUNT, phase=0, word_strobe stays 0.
5. resetn low at phase 2 of a word -> all outputs 0 immediately. After release, locked needs the full 1+8 edge sequence again.
6. LANES=2, data_in=8'hA5 -> lane0 = 1,0,1,0; lane1 = 0,1,0,1; word_strobe pulses once per word.
